// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and hold.
// Optional writeback bypass around the register file: define ID_EX_BYPASS_EN.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_W-1:0]  ex_rn,
  output logic [REG_W-1:0]  ex_rm,
  output logic [REG_W-1:0]  ex_rd,
  output logic [8:0]        ex_ctrl,
  output logic [31:0]       stall_cnt
);

  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
  logic [REG_W-1:0]  ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d, ex_rd_q, ex_rd_d;
  logic [8:0]        ex_ctrl_q, ex_ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic              lu_hazard;
  logic [DATA_W-1:0] src_a, src_b, op_a, op_b;

  assign lu_hazard = id_valid & ex_valid_q & ex_ctrl_q[7] & (ex_rd_q != XZR) &
                     ((ex_rd_q == id_rn) | (ex_rd_q == id_rm));

  // Gated by reset so a pending ex_hold cannot raise a stall while the pipe is cleared.
  assign stall_id = Reset & (lu_hazard | ex_hold) & ~flush;

`ifdef ID_EX_BYPASS_EN
  assign src_a = (wb_regwrite && wb_rd != XZR && wb_rd == id_rn) ? wb_data : id_rd1;
  assign src_b = (wb_regwrite && wb_rd != XZR && wb_rd == id_rm) ? wb_data : id_rd2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};
  assign src_a = id_rd1;
  assign src_b = id_rd2;
`endif

  // XZR wins over both register file data and bypassed data.
  assign op_a = (id_rn == XZR) ? '0 : src_a;
  assign op_b = (id_rm == XZR) ? '0 : src_b;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_imm_d    = ex_imm_q;
    ex_pc_d     = ex_pc_q;
    ex_rn_d     = ex_rn_q;
    ex_rm_d     = ex_rm_q;
    ex_rd_d     = ex_rd_q;
    ex_ctrl_d   = ex_ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (flush || (!ex_hold && lu_hazard)) begin
      ex_valid_d = 1'b0;
      ex_a_d     = '0;
      ex_b_d     = '0;
      ex_imm_d   = '0;
      ex_pc_d    = '0;
      ex_rn_d    = '0;
      ex_rm_d    = '0;
      ex_rd_d    = '0;
      ex_ctrl_d  = '0;
      if (!flush && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end else if (!ex_hold) begin
      ex_valid_d = id_valid;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
      ex_imm_d   = id_imm;
      ex_pc_d    = id_pc;
      ex_rn_d    = id_rn;
      ex_rm_d    = id_rm;
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_valid ? id_ctrl : 9'd0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_pc_q     <= '0;
      ex_rn_q     <= '0;
      ex_rm_q     <= '0;
      ex_rd_q     <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc_q     <= ex_pc_d;
      ex_rn_q     <= ex_rn_d;
      ex_rm_q     <= ex_rm_d;
      ex_rd_q     <= ex_rd_d;
      ex_ctrl_q   <= ex_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_pc     = ex_pc_q;
  assign ex_rn     = ex_rn_q;
  assign ex_rm     = ex_rm_q;
  assign ex_rd     = ex_rd_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the segmented ARMv8 core. It sits directly downstream of the register file and captures the two read operands, immediate, PC, register indices and decoded control bits into one registered bundle for EX. It also detects load-use hazards, inserts bubbles, and honours flush and hold requests. As a build option it bypasses same-cycle writeback data around the register file.

## Interface
Parameters:
- DATA_W, 64, operand/PC/immediate width
- REG_W, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_W  first source index (ReadReg1)
- id_rm  in  REG_W  second source index (ReadReg2)
- id_rd  in  REG_W  destination index
- id_rd1  in  DATA_W  register file ReadData1
- id_rd2  in  DATA_W  register file ReadData2
- id_imm  in  DATA_W  sign-extended immediate
- id_pc  in  DATA_W  instruction PC
- id_ctrl  in  9  [8]RegWrite [7]MemRead [6]MemWrite [5]MemtoReg [4]ALUSrc [3]Branch [2]UncondBranch [1:0]ALUOp
- flush  in  1  taken branch resolved downstream; kill ID instruction
- ex_hold  in  1  downstream freeze (multi-cycle memory)
- wb_regwrite  in  1  writeback enable (bypass only)
- wb_rd  in  REG_W  writeback index (bypass only)
- wb_data  in  DATA_W  writeback data (bypass only)
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX bundle valid
- ex_a, ex_b, ex_imm, ex_pc  out  DATA_W  registered operands/immediate/PC
- ex_rn, ex_rm, ex_rd  out  REG_W  registered indices
- ex_ctrl  out  9  registered control; all-zero when ex_valid=0
- stall_cnt  out  32  count of bubble-insert cycles, saturating

## Operation
- Hazard (combinational): `lu_hazard = id_valid & ex_valid & ex_ctrl[7] & (ex_rd != 31) & (ex_rd == id_rn | ex_rd == id_rm)`.
- `stall_id = (lu_hazard | ex_hold) & ~flush`.
- Per-edge action, highest priority first:
  - flush: load bubble (ex_valid=0, ex_ctrl=0, data regs don't-care but set to 0).
  - ex_hold: keep all ex_* registers unchanged.
  - lu_hazard: load bubble.
  - otherwise: load ID bundle with ex_valid=id_valid. When id_valid=0, ex_ctrl=0.
- Operand select: index 31 (XZR) forces the operand to 0 regardless of id_rd1/id_rd2.
- stall_cnt: increments by 1 on each edge where a bubble is inserted because of lu_hazard. It holds at 32'hFFFF_FFFF and does not wrap. Flush bubbles and holds do not count.
- Reset low: immediately clears every register and output to 0 (ex_valid=0, ex_ctrl=0, stall_cnt=0). stall_id evaluates to 0 during reset. Deassertion is sampled at the next clk edge.

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing rising edge.
- stall_id is combinational from ex_* registers, id_*, flush and ex_hold, in the same cycle. No register in that path.
- A load-use hazard produces exactly one bubble. In the next cycle ex_valid=0, so the hazard clears and the held instruction enters.
- Simultaneous flush+ex_hold: flush wins; the bubble is loaded even though EX is frozen. Downstream is responsible for not consuming it twice.
- Reset asserted mid-hold or mid-stall: state is lost and no instruction is replayed.

## Configuration
- Macro: ID_EX_BYPASS_EN.
- Defined: before capture, the source operand is replaced with wb_data when `wb_regwrite & wb_rd != 31 & wb_rd == id_rn` (for ex_a) or `== id_rm` (for ex_b). This covers a register file that writes on the same edge it is read. XZR forcing still has priority.
- Not defined: wb_* ports exist but are ignored; ex_a and ex_b come from id_rd1 and id_rd2 (or 0 for X31) only.

## Test plan
- Reset: drive Reset=0 mid-cycle with ex_valid=1 -> all outputs 0 immediately (no clk edge), stall_cnt=0.
- Pass-through: id_valid=1, rn=1, rm=2, rd1=64'h11, rd2=64'h22, ctrl=9'h1A0 -> next edge ex_a=11, ex_b=22, ex_ctrl=1A0, ex_valid=1, stall_id=0.
- Load-use: EX holds LDUR with rd=3 (ctrl[7]=1); ID has rn=3 -> stall_id=1, next edge ex_valid=0, stall_cnt=1, following edge the ID instruction is captured. Repeating with rd=31 -> no stall.
- Hold vs flush: ex_hold=1 for 3 cycles -> ex_* constant, stall_id=1. Then ex_hold=1 with flush=1 -> next edge ex_valid=0, ex_ctrl=0, stall_id=0.
- XZR: rn=31, id_rd1=64'hDEAD -> ex_a=0.
- Bypass (ID_EX_BYPASS_EN defined): wb_regwrite=1, wb_rd=2, wb_data=64'h99, rm=2, id_rd2=64'h22 -> ex_b=99. Without the macro -> ex_b=22.
